serial_subtractor: RTL and testbench

//  Multi-cycle bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Purpose: shared FSM state encoding and full-subtractor borrow equation for serial_subtractor.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package serial_subtractor_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Borrow out of one subtractor cell: borrow when a<b, or when a==b and a
  // borrow is already pending.
  function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Purpose: one-bit full subtractor cell, d = a - b - bin with borrow out.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a minuend bit, i_b subtrahend bit, i_bin borrow in,
//        o_d difference bit, o_bout borrow out.
module serial_subtractor_full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = fs_borrow(i_a, i_b, i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Purpose: bit-serial subtractor, diff = a - b - bin mod 2^WIDTH, LSB first, one bit per clock.
// Latency: done pulses in the cycle after edge accept+WIDTH; diff/bout valid from that cycle.
// Backpressure: start is taken only while idle; start during busy is ignored.
// Ports: i_clk clock, i_rst sync active-high reset, i_start request,
//        i_a/i_b operands, i_bin borrow in (captured on accept),
//        o_busy operation in progress, o_done 1-cycle completion pulse,
//        o_diff result, o_bout borrow out (1 iff a < b+bin unsigned).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_brw;
  logic             r_done;
  logic             r_bout;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_d;
  logic             w_brw_nxt;

  assign w_run    = (r_state == S_RUN);
  assign w_accept = (r_state == S_IDLE) && i_start;
  assign w_last   = w_run && (r_cnt == LAST_CNT);

  serial_subtractor_full_subtractor u_fs (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_bin  (r_brw),
    .o_d    (w_d),
    .o_bout (w_brw_nxt)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // first (LSB) bit has reached position 0. Written this way to stay legal
  // for WIDTH=1.
  always_comb begin
    w_res_nxt            = r_res >> 1;
    w_res_nxt[WIDTH-1]   = w_d;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST_CNT) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Operands are loaded only here, so idle X/garbage on the inputs
        // never reaches the datapath.
        r_a_sh <= i_a;
        r_b_sh <= i_b;
        r_brw  <= i_bin;
        r_cnt  <= '0;
      end else if (w_run) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_brw  <= w_brw_nxt;
        r_res  <= w_res_nxt;
        r_cnt  <= r_cnt + 1'b1;
        // Visible outputs update only on completion; they hold the previous
        // result while a new operation runs.
        if (w_last) begin
          r_done <= 1'b1;
          r_diff <= w_res_nxt;
          r_bout <= w_brw_nxt;
        end
      end
    end
  end

  assign o_busy = w_run;
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;
  logic [7:0] a_in = 8'h0, b_in = 8'h0;
  logic       bin_in = 1'b0;

  logic       busy1, done1, bout1;
  logic [0:0] diff1;
  logic       busy4, done4, bout4;
  logic [3:0] diff4;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         w;
    logic [7:0] diff;
    logic       bout;
    int         due;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_a(a_in[0:0]), .i_b(b_in[0:0]),
    .i_bin(bin_in), .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bout(bout1)
  );
  serial_subtractor #(.WIDTH(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_start(start4), .i_a(a_in[3:0]), .i_b(b_in[3:0]),
    .i_bin(bin_in), .o_busy(busy4), .o_done(done4), .o_diff(diff4), .o_bout(bout4)
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a_in), .i_b(b_in),
    .i_bin(bin_in), .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_bout(bout8)
  );

  // Reference: unsigned arithmetic on masked operands.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input int due);
    exp_t e;
    int   m, av, bv;
    m      = (1 << w) - 1;
    av     = int'(a) & m;
    bv     = int'(b) & m;
    e.w    = w;
    e.diff = 8'((av - bv - int'(bin)) & m);
    e.bout = (av < bv + int'(bin));
    e.due  = due;
    return e;
  endfunction

  // Scoreboard consumer: every done pulse pops one expectation and checks
  // value and timing; an expectation past its due cycle is a missing done.
  task automatic monitor();
    exp_t       e;
    logic [7:0] dv;
    logic       bv;
    logic [2:0] dn, want;
    forever begin
      @(negedge clk);
      dn = {done8, done4, done1};
      if (dn != 3'b000) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done={8,4,1}=%b at cycle %0d, required no done", dn, cyc);
        end else begin
          e = q.pop_front();
          case (e.w)
            1:       begin dv = {7'b0, diff1}; bv = bout1; want = 3'b001; end
            4:       begin dv = {4'b0, diff4}; bv = bout4; want = 3'b010; end
            default: begin dv = diff8;         bv = bout8; want = 3'b100; end
          endcase
          if (dn !== want) begin
            errors++;
            $display("FAIL done_sel w=%0d: done=%b, required %b", e.w, dn, want);
          end
          checks++;
          if (dv !== e.diff) begin
            errors++;
            $display("FAIL diff w=%0d: got %h, required %h", e.w, dv, e.diff);
          end
          checks++;
          if (bv !== e.bout) begin
            errors++;
            $display("FAIL bout w=%0d: got %b, required %b", e.w, bv, e.bout);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL done_timing w=%0d: done at cycle %0d, required %0d", e.w, cyc, e.due);
          end
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_done w=%0d: no done by cycle %0d, required at %0d", q[0].w, cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  endtask

  // Drive one start pulse at a negedge and queue the expected completion.
  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    bin_in = bin;
    case (w)
      1:       start1 = 1'b1;
      4:       start4 = 1'b1;
      default: start8 = 1'b1;
    endcase
    q.push_back(model(w, a, b, bin, cyc + 1 + w));
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wait_idle: %0d ops still pending after 50 cycles, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_busy4: got %b, required 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL rst_done4: got %b, required 0", done4); end
    checks++; if (diff4 !== 4'h0) begin errors++; $display("FAIL rst_diff4: got %h, required 0", diff4); end
    checks++; if (bout4 !== 1'b0) begin errors++; $display("FAIL rst_bout4: got %b, required 0", bout4); end
    checks++; if ({busy1, done1, bout1, diff1} !== 4'b0) begin
      errors++; $display("FAIL rst_w1: busy,done,bout,diff=%b, required 0000", {busy1, done1, bout1, diff1});
    end
    checks++; if ({busy8, done8, bout8, diff8} !== 11'b0) begin
      errors++; $display("FAIL rst_w8: busy,done,bout,diff=%b, required 0", {busy8, done8, bout8, diff8});
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [7:0] va[5] = '{8'h9, 8'h3, 8'h0, 8'hF, 8'hF};
    logic [7:0] vb[5] = '{8'h3, 8'h9, 8'h0, 8'hF, 8'h0};
    logic       vc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      issue(4, va[i], vb[i], vc[i]);
      a_in = 8'hA5; b_in = 8'h5A; bin_in = 1'b1;
      wait_idle();
    end
  endtask

  task automatic test_ignore_busy();
    issue(4, 8'h9, 8'h3, 1'b0);
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL ignore_busy: busy=%b, required 1", busy4); end
    a_in = 8'h1; b_in = 8'h1; bin_in = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4, 8'h6, 8'h1, 1'b0);
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++; $display("FAIL b2b_wait: done=%b, required 1 within 20 cycles", done4);
    end
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_busy_done: busy=%b, required 0", busy4); end
    a_in = 8'h5; b_in = 8'h2; bin_in = 1'b0; start4 = 1'b1;
    q.push_back(model(4, 8'h5, 8'h2, 1'b0, cyc + 1 + 4));
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b, required 1", busy4); end
    checks++;
    if (done4 !== 1'b0) begin errors++; $display("FAIL b2b_pulse: done=%b, required 0", done4); end
    checks++;
    if (diff4 !== 4'h5) begin errors++; $display("FAIL b2b_hold: diff=%h, required 5", diff4); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    issue(4, 8'h9, 8'h3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    checks++;
    if ({busy4, done4, bout4, diff4} !== 7'b0) begin
      errors++; $display("FAIL rst_mid: busy,done,bout,diff=%b, required 0", {busy4, done4, bout4, diff4});
    end
    start4 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL rst_wins: busy=%b, required 0", busy4); end
    start4 = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
        errors++; $display("FAIL rst_no_done: done=%b busy=%b, required 0 0", done4, busy4);
      end
    end
  endtask

  task automatic test_random();
    int ws[3] = '{1, 4, 8};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12; i++) begin
        issue(ws[k], 8'($urandom), 8'($urandom), 1'($urandom));
        a_in = 8'($urandom); b_in = 8'($urandom); bin_in = 1'($urandom);
        wait_idle();
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_vectors();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
